// File: rtl/main_mem_ctrl_if.sv
// Request/response bus between the processing block and the main vector memory.
// Optional lane mask (MAIN_MEM_LANE_MASK_EN) adds req_mask to the request channel.
interface main_mem_ctrl_if #(
  parameter int CORES = 32,
  parameter int BITS  = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [15:0]             req_addr;
  logic [CORES*BITS-1:0]   req_wdata;
`ifdef MAIN_MEM_LANE_MASK_EN
  logic [CORES-1:0]        req_mask;
`endif
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [CORES*BITS-1:0]   rsp_data;
  logic                    rsp_err;
  logic                    busy;

`ifdef MAIN_MEM_LANE_MASK_EN
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
`endif
endinterface

// File: rtl/main_mem_ctrl.sv
// Main vector memory controller: DEPTH words of CORES*BITS bits, one request
// outstanding, fixed LATENCY from accept to response, valid/ready on both sides.
// Optional feature macro: MAIN_MEM_LANE_MASK_EN (per-lane write enables).
module main_mem_ctrl #(
  parameter int CORES   = 32,
  parameter int BITS    = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  main_mem_ctrl_if.slave   bus
);
  localparam int          W        = CORES * BITS;
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic [W-1:0]     rsp_data_q;

  logic             wr_q;
  logic [15:0]      addr_q;
  logic [W-1:0]     wdata_q;
  logic [CORES-1:0] lane_en;

  logic [W-1:0]     mem_q [DEPTH];

  logic             accept;
  logic             commit;
  logic             in_range;
  logic [AW-1:0]    idx;

  assign accept   = bus.req_valid && req_ready_q;
  assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  // Index is only consumed when in_range is true.
  assign idx      = addr_q[AW-1:0];

`ifdef MAIN_MEM_LANE_MASK_EN
  logic [CORES-1:0] mask_q;
  // Lane mask captured together with the rest of the request.
  always_ff @(posedge clock) begin
    if (accept) mask_q <= bus.req_mask;
  end
  assign lane_en = mask_q;
`else
  assign lane_en = '1;
`endif

  // Latch request fields at accept; the core may change them afterwards.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Write commit on the final WAIT edge; out-of-range writes are dropped.
  always_ff @(posedge clock) begin
    if (commit && wr_q && in_range) begin
      for (int i = 0; i < CORES; i++) begin
        if (lane_en[i]) mem_q[idx][i*BITS +: BITS] <= wdata_q[i*BITS +: BITS];
      end
    end
  end

  // Control FSM IDLE -> WAIT -> RESP -> IDLE with registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_WAIT;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !in_range;
            // Writes leave rsp_data at its previous value.
            if (!wr_q) rsp_data_q <= in_range ? mem_q[idx] : '0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed cases plus randomized traffic
// compared against a word-level memory model. Honors MAIN_MEM_LANE_MASK_EN.
module tb_main_mem_ctrl;
  localparam int CORES   = 32;
  localparam int BITS    = 16;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int W       = CORES * BITS;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  main_mem_ctrl_if #(.CORES(CORES), .BITS(BITS)) bus();

  main_mem_ctrl #(.CORES(CORES), .BITS(BITS), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: written words only, plus the expected response register.
  logic [W-1:0] mem_m [int];
  logic [W-1:0] exp_rsp;
  bit           exp_known;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_req(input bit wr, input logic [15:0] a, input logic [W-1:0] d,
                           input logic [CORES-1:0] m);
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef MAIN_MEM_LANE_MASK_EN
    bus.req_mask  = m;
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check("req_ready_before_req", 1'(bus.req_ready), 1'b1);
  endtask

  // One complete transaction with optional response backpressure.
  task automatic xact(input bit wr, input logic [15:0] a, input logic [W-1:0] d,
                      input logic [CORES-1:0] m, input int stall);
    bit           inr;
    int           lat;
    logic [W-1:0] merged;
    inr = (int'(a) < DEPTH);
    if (!wr) begin
      if (!inr) begin
        exp_rsp = '0; exp_known = 1'b1;
      end else if (mem_m.exists(int'(a))) begin
        exp_rsp = mem_m[int'(a)]; exp_known = 1'b1;
      end else begin
        exp_known = 1'b0;
      end
    end else if (inr) begin
      merged = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
`ifdef MAIN_MEM_LANE_MASK_EN
      for (int i = 0; i < CORES; i++)
        if (m[i]) merged[i*BITS +: BITS] = d[i*BITS +: BITS];
`else
      merged = d;
`endif
      mem_m[int'(a)] = merged;
    end

    wait_ready();
    bus.rsp_ready = (stall == 0);
    bus.req_valid = 1'b1;
    drive_req(wr, a, d, m);
    @(posedge clock); #1;
    // Scramble request inputs: only the latched copy may matter.
    bus.req_valid = 1'b0;
    drive_req(~wr, 16'($urandom), rand_word(), CORES'($urandom));
    check("wait_req_ready", 1'(bus.req_ready), 1'b0);
    check("wait_busy", 1'(bus.busy), 1'b1);

    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    check("latency", W'(lat), W'(LATENCY));
    check("rsp_err", 1'(bus.rsp_err), 1'(!inr));
    if (exp_known) check("rsp_data", bus.rsp_data, exp_rsp);

    for (int s = 0; s < stall; s++) begin
      bus.req_valid = 1'b1;
      @(posedge clock); #1;
      check("stall_rsp_valid", 1'(bus.rsp_valid), 1'b1);
      check("stall_req_ready", 1'(bus.req_ready), 1'b0);
      check("stall_rsp_err", 1'(bus.rsp_err), 1'(!inr));
      if (exp_known) check("stall_rsp_data", bus.rsp_data, exp_rsp);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    check("post_rsp_valid", 1'(bus.rsp_valid), 1'b0);
    check("post_req_ready", 1'(bus.req_ready), 1'b1);
    check("post_busy", 1'(bus.busy), 1'b0);
    bus.rsp_ready = 1'($urandom);
  endtask

  logic [W-1:0]     w3f80;
  logic [W-1:0]     v7;
  logic [W-1:0]     d;
  logic [CORES-1:0] full;
  logic [15:0]      a;
  int               pick;

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    full = '1;
    drive_req(1'b0, 16'd0, '0, full);
    exp_rsp = '0; exp_known = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 1'(bus.req_ready), 1'b1);
    check("rst_rsp_valid", 1'(bus.rsp_valid), 1'b0);
    check("rst_rsp_data", bus.rsp_data, '0);
    check("rst_busy", 1'(bus.busy), 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Seed address 0, then the write/read of the 3F80 pattern at address 5
    xact(1'b1, 16'd0, rand_word(), full, 0);
    w3f80 = {32{16'h3F80}};
    xact(1'b1, 16'd5, w3f80, full, 0);
    xact(1'b0, 16'd5, '0, full, 0);
    check("rd5_pattern", bus.rsp_data, w3f80);

    // Backpressure: read held for 5 cycles
    xact(1'b0, 16'd5, '0, full, 5);

    // Out of range
    xact(1'b1, 16'd1024, rand_word(), full, 0);
    xact(1'b0, 16'd1024, '0, full, 1);
    check("oor_rd_zero", bus.rsp_data, '0);
    xact(1'b0, 16'd0, '0, full, 0);
    xact(1'b0, 16'hFFFF, '0, full, 0);

    // Reset during WAIT of a write to address 7
    v7 = rand_word();
    xact(1'b1, 16'd7, v7, full, 0);
    wait_ready();
    bus.req_valid = 1'b1;
    drive_req(1'b1, 16'd7, ~v7, full);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_req_ready", 1'(bus.req_ready), 1'b1);
    check("midrst_rsp_valid", 1'(bus.rsp_valid), 1'b0);
    check("midrst_busy", 1'(bus.busy), 1'b0);
    check("midrst_rsp_data", bus.rsp_data, '0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    exp_rsp = '0; exp_known = 1'b1;
    @(posedge clock); #1;
    xact(1'b0, 16'd7, '0, full, 0);
    check("midrst_rd7", bus.rsp_data, v7);

`ifdef MAIN_MEM_LANE_MASK_EN
    // Lane mask: only lane 0 updated over a zeroed word; all-zero mask is a no-op
    xact(1'b1, 16'd9, '0, full, 0);
    xact(1'b1, 16'd9, '1, 32'h0000_0001, 0);
    xact(1'b0, 16'd9, '0, full, 0);
    d = '0; d[15:0] = 16'hFFFF;
    check("mask_lane0", bus.rsp_data, d);
    xact(1'b1, 16'd9, '1, '0, 0);
    xact(1'b0, 16'd9, '0, full, 0);
    check("mask_zero", bus.rsp_data, d);
    xact(1'b1, 16'd1024, '1, '0, 0);
`endif

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      pick = $urandom_range(0, 9);
      if (pick < 7)       a = 16'($urandom_range(0, 15));
      else if (pick == 7) a = 16'd1023;
      else                a = 16'($urandom_range(1024, 65535));
      xact(1'($urandom), a, rand_word(), full, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule
